// File: rtl/frame_assemble.sv
// ---------------------------------------------------------------------------
// frame_assemble
//   Serial subframe transmitter. Takes 20-bit audio samples plus a 4-bit aux
//   nibble over a valid/ready handshake and serializes 32-bit subframes
//   (A then B per frame, FRAMES frames per block) at one bit per BIT_DIV
//   clocks. It inserts the valid, user and channel-status bits and the even
//   parity bit. The channel-status stream carries the latched cs_word in
//   frames 0..31 and a CRC-8 (poly 0x1D, init 0xFF) in frames 184..191.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : start/continue streaming, sampled only at block boundaries
//   din, auxin     : sample and aux nibble, MSB sent first
//   din_valid      : sample available
//   din_ready      : accept strobe, combinational, high in the bit-0 cycle
//   cs_word        : channel-status word, latched at block start
//   dout, vout     : serial bit and its one-cycle valid strobe
//   out_channel    : 0 = subframe A, 1 = subframe B
//   frame_counter  : frame index within block
//   block_start    : pulses with vout of frame 0 / A / bit 0
//   underrun       : pulses with vout of bit 0 when no sample was available
// ---------------------------------------------------------------------------
module frame_assemble #(
    parameter int BIT_DIV = 4,
    parameter int FRAMES  = 192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [19:0] din,
    input  logic [3:0]  auxin,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] cs_word,
    output logic        dout,
    output logic        vout,
    output logic        out_channel,
    output logic [7:0]  frame_counter,
    output logic        block_start,
    output logic        underrun
);

    localparam int              DIV_W      = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [7:0]      FRAME_LAST = 8'(FRAMES - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [DIV_W-1:0]   r_div;
    logic [4:0]         r_bit;
    logic               r_chan;
    logic [7:0]         r_frame;
    logic [31:0]        r_cs;
    logic [7:0]         r_crc;
    logic [3:0]         r_aux;
    logic [19:0]        r_data;
    logic               r_uflag;
    logic               r_par;

    logic               r_dout;
    logic               r_vout;
    logic               r_out_channel;
    logic [7:0]         r_frame_counter;
    logic               r_block_start;
    logic               r_underrun;

    logic               w_emit;
    logic               w_bit_end;
    logic               w_block_end;
    logic               w_sub_start;
    logic               w_restart;
    logic               w_bit;
    logic               w_cs_bit;
    logic [4:0]         w_aux_pos;
    logic [4:0]         w_dat_pos;
    logic [4:0]         w_cs_pos;
    logic               w_crc_fb;
    logic [7:0]         w_crc_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (enable) w_state_next = S_SEND;
            S_SEND: if (w_block_end && !enable) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: control outputs ----------------
    always_comb begin
        w_emit      = (r_state == S_SEND) && (r_div == '0);
        w_bit_end   = (r_state == S_SEND) && (r_div == DIV_LAST);
        w_block_end = w_bit_end && (r_bit == 5'd31) && r_chan && (r_frame == FRAME_LAST);
        w_sub_start = w_emit && (r_bit == 5'd0);
        // A block starts either from IDLE or back-to-back at the block end.
        w_restart   = ((r_state == S_IDLE) && enable) || (w_block_end && enable);
        din_ready   = w_sub_start && din_valid;
    end

    // ---------------- channel-status bit for the current frame ----------------
    always_comb begin
        w_cs_pos = 5'd31 - r_frame[4:0];
        w_cs_bit = 1'b0;
        if (r_frame < 8'd32) begin
            w_cs_bit = r_cs[w_cs_pos];
        end else if (r_frame >= 8'd184) begin
            // Frames 184..191 shift the frozen CRC out MSB first; the low
            // three frame bits run 0..7 over that range.
            w_cs_bit = r_crc[~r_frame[2:0]];
        end
    end

    assign w_crc_fb   = r_crc[7] ^ w_cs_bit;
    assign w_crc_next = {r_crc[6:0], 1'b0} ^ (w_crc_fb ? 8'h1D : 8'h00);

    // ---------------- bit selection ----------------
    always_comb begin
        w_aux_pos = 5'd3 - r_bit;
        w_dat_pos = 5'd23 - r_bit;
        w_bit     = 1'b0;
        if (r_bit == 5'd0) begin
            // Bit 0 is sent straight from the input being captured this cycle.
            w_bit = din_valid & auxin[3];
        end else if (r_bit < 5'd4) begin
            w_bit = r_aux[w_aux_pos[1:0]];
        end else if (r_bit < 5'd24) begin
            w_bit = r_data[w_dat_pos];
        end else if (r_bit == 5'd24) begin
            w_bit = r_uflag;
        end else if (r_bit == 5'd26) begin
            w_bit = w_cs_bit;
        end else if (r_bit == 5'd31) begin
            w_bit = r_par;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div           <= '0;
            r_bit           <= '0;
            r_chan          <= 1'b0;
            r_frame         <= '0;
            r_cs            <= '0;
            r_crc           <= 8'hFF;
            r_aux           <= '0;
            r_data          <= '0;
            r_uflag         <= 1'b0;
            r_par           <= 1'b0;
            r_dout          <= 1'b0;
            r_vout          <= 1'b0;
            r_out_channel   <= 1'b0;
            r_frame_counter <= '0;
            r_block_start   <= 1'b0;
            r_underrun      <= 1'b0;
        end else begin
            if (w_restart) begin
                r_cs    <= cs_word;
                r_crc   <= 8'hFF;
                r_div   <= '0;
                r_bit   <= '0;
                r_chan  <= 1'b0;
                r_frame <= '0;
            end else if (r_state == S_SEND) begin
                if (w_bit_end) begin
                    r_div <= '0;
                    r_bit <= r_bit + 5'd1;
                    if (r_bit == 5'd31) begin
                        r_chan <= ~r_chan;
                        if (r_chan) r_frame <= r_frame + 8'd1;
                    end
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
                // Only subframe A's channel bits before frame 184 feed the CRC.
                if (w_emit && (r_bit == 5'd26) && !r_chan && (r_frame < 8'd184)) begin
                    r_crc <= w_crc_next;
                end
            end

            if (w_sub_start) begin
                r_aux   <= din_valid ? auxin : 4'h0;
                r_data  <= din_valid ? din : 20'h0;
                r_uflag <= ~din_valid;
            end

            // Running XOR of bits 0..30 becomes bit 31.
            if (w_emit) begin
                r_par <= (r_bit == 5'd0) ? w_bit : (r_par ^ w_bit);
            end

            r_vout        <= w_emit;
            r_block_start <= w_sub_start && !r_chan && (r_frame == 8'd0);
            r_underrun    <= w_sub_start && !din_valid;

            if (w_emit) begin
                r_dout          <= w_bit;
                r_out_channel   <= r_chan;
                r_frame_counter <= r_frame;
            end else if (r_state == S_IDLE) begin
                r_dout <= 1'b0;
            end
        end
    end

    assign dout          = r_dout;
    assign vout          = r_vout;
    assign out_channel   = r_out_channel;
    assign frame_counter = r_frame_counter;
    assign block_start   = r_block_start;
    assign underrun      = r_underrun;

endmodule

// File: tb/tb_frame_assemble.sv
module tb_frame_assemble;

    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [19:0] din = '0;
    logic [3:0]  auxin = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [31:0] cs_word = '0;
    logic        dout;
    logic        vout;
    logic        out_channel;
    logic [7:0]  frame_counter;
    logic        block_start;
    logic        underrun;

    frame_assemble #(.BIT_DIV(BD), .FRAMES(192)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .din(din), .auxin(auxin), .din_valid(din_valid), .din_ready(din_ready),
        .cs_word(cs_word), .dout(dout), .vout(vout), .out_channel(out_channel),
        .frame_counter(frame_counter), .block_start(block_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit aborted = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Channel-status stream of one block: cs word, zeros, then the CRC-8
    // of the first 184 bits, MSB first. v[f] is the bit for frame f.
    function automatic logic [191:0] cs_model(input logic [31:0] cs);
        logic [191:0] v;
        logic [7:0]   crc;
        logic         fb;
        v   = '0;
        crc = 8'hFF;
        for (int f = 0; f < 32; f++) v[f] = cs[31-f];
        for (int f = 0; f < 184; f++) begin
            fb  = crc[7] ^ v[f];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
        end
        for (int k = 0; k < 8; k++) v[184+k] = crc[7-k];
        return v;
    endfunction

    // Subframe in send order, first bit at [31].
    function automatic logic [31:0] make_word(input logic [3:0] a, input logic [19:0] d,
                                              input logic v, input logic c);
        logic [30:0] body;
        body = {v ? a : 4'h0, v ? d : 20'h0, ~v, 1'b0, c, 4'h0};
        return {body, ^body};
    endfunction

    int           m_sub = 0;
    logic [191:0] m_csv = '0;
    bit           m_first = 1;

    // Collect one subframe; checks bit spacing and that the side outputs stay
    // stable (and pulses stay low) after bit 0.
    task automatic recv_word(input bit first, output logic [31:0] w, output logic [7:0] fc,
                             output logic ch, output logic bs, output logic ur,
                             output int rdy, output bit ok);
        int n;
        w = '0; fc = '0; ch = 0; bs = 0; ur = 0; rdy = 0; ok = 1;
        for (int b = 0; b < 32; b++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (din_ready) rdy++;
            end while (!vout && n < BD + 4);
            if (!vout) begin
                check("vout_timeout", {31'b0, vout}, 32'd1);
                ok = 0;
                return;
            end
            if (!(first && b == 0)) check("vout_gap", n, BD);
            w = {w[30:0], dout};
            if (b == 0) begin
                fc = frame_counter; ch = out_channel; bs = block_start; ur = underrun;
            end else begin
                check("meta_stable", {frame_counter, out_channel, block_start, underrun},
                      {fc, ch, 2'b00});
            end
        end
    endtask

    // Stream nsub subframes against the model. Inputs for the next subframe
    // are driven at the negedge that shows bit 31, well before its bit 0.
    task automatic run(input int nsub, input bit rnd, input int uf_frame, input int drop_sub,
                       input int cs_sub, input logic [31:0] cs_new, output int n_ur);
        logic [31:0] w;
        logic [7:0]  fc;
        logic        ch, bs, ur, ev;
        logic [19:0] ed;
        logic [3:0]  ea;
        int          rdy, nf;
        bit          ok;
        n_ur = 0;
        for (int i = 0; i < nsub; i++) begin
            ev = din_valid; ed = din; ea = auxin;
            recv_word(m_first, w, fc, ch, bs, ur, rdy, ok);
            m_first = 0;
            if (!ok) begin aborted = 1; return; end
            check("frame_counter", {24'b0, fc}, m_sub / 2);
            check("out_channel", {31'b0, ch}, m_sub % 2);
            check("block_start", {31'b0, bs}, (m_sub == 0) ? 1 : 0);
            check("underrun", {31'b0, ur}, {31'b0, ~ev});
            check("din_ready_cnt", rdy, ev ? 1 : 0);
            check("subframe", w, make_word(ea, ed, ev, m_csv[m_sub/2]));
            $display("sub %0d f=%0d ch=%0d word=%h valid=%0d", m_sub, fc, ch, w, ev);
            if (ur) n_ur++;
            if (m_sub == drop_sub) enable = 1'b0;
            if (m_sub == cs_sub) cs_word = cs_new;
            nf = ((m_sub + 1) % 384) / 2;
            if (rnd) begin
                din   = 20'($urandom);
                auxin = 4'($urandom);
            end
            din_valid = (nf == uf_frame) ? 1'b0 : (rnd ? ($urandom_range(5) != 0) : 1'b1);
            m_sub++;
            if (m_sub == 384) begin
                m_sub = 0;
                if (enable) m_csv = cs_model(cs_word);
                else begin m_first = 1; return; end
            end
        end
    endtask

    task automatic reset_mid_and_check();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_zero", {19'b0, dout, vout, din_ready, out_channel, frame_counter,
                              block_start, underrun}, 32'd0);
    endtask

    typedef struct {
        logic [19:0] d;
        logic [3:0]  a;
        logic        v;
        logic [31:0] cs;
        logic [31:0] w;
        logic        ur;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] w;
        logic [7:0]  fc;
        logic        ch, bs, ur;
        int          rdy, n_ur, cnt;
        bit          ok;

        tbl[0] = '{20'hABCDE, 4'h5, 1'b1, 32'h8000_0001, 32'h5ABC_DE20, 1'b0};
        tbl[1] = '{20'hABCDE, 4'h5, 1'b1, 32'h0000_0000, 32'h5ABC_DE01, 1'b0};
        tbl[2] = '{20'h00000, 4'h0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[3] = '{20'hFFFFF, 4'hF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF21, 1'b0};
        tbl[4] = '{20'h12345, 4'h9, 1'b0, 32'h8000_0000, 32'h0000_00A0, 1'b1};
        tbl[5] = '{20'h00001, 4'h8, 1'b1, 32'h0000_0000, 32'h8000_0100, 1'b0};

        repeat (3) @(negedge clk);

        // ---- table: first subframe after reset, then async reset mid-stream ----
        for (int i = 0; i < 6 && !aborted; i++) begin
            reset_mid_and_check();
            din = tbl[i].d; auxin = tbl[i].a; din_valid = tbl[i].v;
            cs_word = tbl[i].cs; enable = 1'b1;
            @(negedge clk);
            rst_n = 1'b1;
            recv_word(1'b1, w, fc, ch, bs, ur, rdy, ok);
            if (!ok) begin aborted = 1; break; end
            check("tbl_word", w, tbl[i].w);
            check("tbl_meta", {fc, ch, bs, ur}, {8'd0, 1'b0, 1'b1, tbl[i].ur});
            check("tbl_ready", rdy, tbl[i].v ? 1 : 0);
            $display("vec %0d word=%h want=%h", i, w, tbl[i].w);
            repeat (5) @(negedge clk);
        end

        // ---- full block: cs 8000_0001, underrun in frame 5, enable dropped at frame 100 ----
        if (!aborted) begin
            reset_mid_and_check();
            din = 20'hABCDE; auxin = 4'h5; din_valid = 1'b1;
            cs_word = 32'h8000_0001; enable = 1'b1;
            m_sub = 0; m_csv = cs_model(cs_word); m_first = 1;
            @(negedge clk);
            rst_n = 1'b1;
            run(384, 1'b0, 5, 200, -1, 32'h0, n_ur);
            check("underrun_pulses", n_ur, 2);
            check("block_ended", m_sub, 0);
        end

        // ---- idle after the block ----
        if (!aborted) begin
            cnt = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (vout) cnt++;
            end
            check("idle_vout", cnt, 0);
        end

        // ---- random block, enable held across the boundary, cs changed mid-block ----
        if (!aborted) begin
            din = 20'($urandom); auxin = 4'($urandom); din_valid = 1'b1;
            cs_word = $urandom; enable = 1'b1;
            m_sub = 0; m_csv = cs_model(cs_word); m_first = 1;
            run(390, 1'b1, -1, -1, 200, $urandom, n_ur);
        end

        // ---- async reset mid-subframe, restart at frame 0 A ----
        if (!aborted) begin
            reset_mid_and_check();
            din = 20'h0F0F0; auxin = 4'hC; din_valid = 1'b1; enable = 1'b1;
            m_sub = 0; m_csv = cs_model(cs_word); m_first = 1;
            @(negedge clk);
            rst_n = 1'b1;
            run(2, 1'b0, -1, -1, -1, 32'h0, n_ur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_assemble.md
Name: frame_assemble

Overview:
- Serial subframe transmitter; the far-end counterpart of the subframe receiver in the optical link.
- Accepts 20-bit audio samples with 4-bit aux through a valid/ready handshake, plus one 32-bit channel-status word per block.
- Serializes 32-bit subframes (channel A then B per frame, 192 frames per block) at one bit every BIT_DIV clocks.
- Generates the valid, user, channel-status, CRC-8 and even-parity fields; feeds the optical line encoder.

Parameters:
BIT_DIV, 4, clocks per serial bit (>=2)
FRAMES, 192, frames per block (fixed layout requires 192)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  start/continue streaming; sampled only at block boundaries
din  in  20  audio sample, MSB sent first
auxin  in  4  aux nibble, MSB sent first
din_valid  in  1  sample/aux available
din_ready  out  1  one-cycle accept strobe
cs_word  in  32  channel-status word, latched at block start
dout  out  1  serial bit
vout  out  1  one-cycle strobe, dout valid
out_channel  out  1  0 = subframe A, 1 = subframe B
frame_counter  out  8  frame index 0..191 within block
block_start  out  1  pulse with bit 0 of frame 0, subframe A
underrun  out  1  pulse when a subframe starts without a sample

Behaviour:
- Reset values: all outputs 0, state IDLE, CRC register 8'hFF, bit divider 0.
- States:
  - IDLE: outputs quiet. When enable=1, latch cs_word, set CRC=8'hFF, frame 0, subframe A, bit 0, go to SEND.
  - SEND: divider counts 0..BIT_DIV-1. At count 0, one bit is driven on dout with vout=1 for that single cycle. dout holds its value until the next bit.
  - After bit 31 of subframe B in frame 191, sample enable: 1 starts a new block immediately (no gap bit, cs_word re-latched); 0 returns to IDLE.
- Subframe bit order:
  - bits 0-3: aux
  - bits 4-23: data
  - bit 24: valid (0 = valid)
  - bit 25: user (always 0)
  - bit 26: channel-status bit
  - bits 27-30: 0
  - bit 31: parity = XOR of bits 0-30, so each subframe has even weight
- Sample handshake: at bit 0 of every subframe, if din_valid=1, capture din/auxin and pulse din_ready in that same cycle. The transfer is din_valid && din_ready. Bit 0 is emitted from the captured auxin[3].
- Underrun: if din_valid=0 at bit 0, send aux=0, data=0, valid bit=1, pulse underrun. din_ready stays 0 for that subframe.
- Channel-status bit for frame f (same value in A and B):
  - f=0..31: cs_word[31-f]
  - f=32..183: 0
  - f=184..191: CRC register MSB first
- CRC-8, poly 0x1D, init 0xFF, no reflection, xorout 0:
  - Updates on each subframe-A channel bit for f<184: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h1D : 0).
  - From f=184 the CRC is frozen and shifted out. B subframes never update it.
- block_start is coincident with vout of frame 0, A, bit 0.
- out_channel and frame_counter are stable for all 32 bits of a subframe.
- Async reset mid-subframe: immediate return to reset values. No partial bits are completed after release.
- enable deasserted mid-block: ignored until the block ends.

Test Plan:
- Reset, enable=1, din_valid=1, din=20'hABCDE, auxin=4'h5 constant. First subframe bits are 0101 1010 1011 1100 1101 1110 0 0 cs 0000 p, with p making even weight. vout is spaced exactly BIT_DIV clocks; din_ready pulses once per subframe.
- cs_word=32'h8000_0001 over a full block. Channel bit is 1 at frames 0 and 31, 0 for frames 1-30 and 32-183. Frames 184-191 equal the bench-model CRC-8 (0x1D, init FF) over those 184 bits, and A/B copies match.
- din_valid held 0 during frame 5. Both frame-5 subframes have data=0, valid bit=1, underrun pulses twice, din_ready stays 0, parity still even.
- enable dropped during frame 100. The block completes through frame 191 subframe B bit 31, then returns to IDLE. The next enable restarts at frame 0 with a block_start pulse.
- enable held high across a block boundary with cs_word changed mid-block. The new block begins with no gap and uses the cs_word value present at the boundary; the CRC restarts at FF.
- rst_n asserted mid-subframe. All outputs are 0 asynchronously. After release with enable=1, the first bit is frame 0, A, bit 0.
